// File: rtl/eop_detect.sv
// eop_detect: USB end-of-packet / bus-reset detector on the sampled D+/D- pair.
// Ports:
//   clk          - single clock, rising edge
//   rst          - synchronous active-high reset
//   d_plus       - D+ level, already synchronized to clk
//   d_minus      - D- level, already synchronized to clk
//   shift_enable - one-cycle bit-sample strobe
//   eop          - combinational SE0 indicator
//   eop_done     - registered one-cycle pulse on a valid EOP (SE0 x2..3 then J)
//   eop_error    - registered one-cycle pulse on a malformed EOP
//   bus_reset    - high while SE0 has lasted 4 or more bit samples
module eop_detect (
    input  logic clk,
    input  logic rst,
    input  logic d_plus,
    input  logic d_minus,
    input  logic shift_enable,
    output logic eop,
    output logic eop_done,
    output logic eop_error,
    output logic bus_reset
);
    typedef enum logic [2:0] {IDLE, SE0_1, SE0_2, SE0_3, BUS_RST} state_t;
    state_t state_q;
    logic   done_q, err_q;
    logic   se0, j;
    assign se0       = !d_plus && !d_minus;
    assign j         = d_plus && !d_minus;
    assign eop       = se0;
    assign eop_done  = done_q;
    assign eop_error = err_q;
    assign bus_reset = state_q == BUS_RST;
    // Pulses default low each cycle so they last exactly one cycle after the strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (shift_enable) begin
                case (state_q)
                    IDLE:    state_q <= se0 ? SE0_1 : IDLE;
                    SE0_1: begin
                        state_q <= se0 ? SE0_2 : IDLE;
                        err_q   <= !se0;
                    end
                    SE0_2, SE0_3: begin
                        state_q <= se0 ? (state_q == SE0_2 ? SE0_3 : BUS_RST) : IDLE;
                        done_q  <= j;
                        err_q   <= !se0 && !j;
                    end
                    BUS_RST: state_q <= se0 ? BUS_RST : IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_eop_detect.sv
// tb_eop_detect: directed and random checks of eop_detect against a run-length model.
module tb_eop_detect;
    localparam int LS_SE0 = 0, LS_J = 1, LS_K = 2, LS_SE1 = 3;
    logic clk = 1'b0, clk_en = 1'b0;
    logic rst = 1'b1, d_plus = 1'b1, d_minus = 1'b0, shift_enable = 1'b0;
    logic eop, eop_done, eop_error, bus_reset;
    int   tests = 0, fails = 0;
    int   run = 0;
    logic exp_done = 1'b0, exp_err = 1'b0;

    eop_detect dut (
        .clk(clk), .rst(rst), .d_plus(d_plus), .d_minus(d_minus),
        .shift_enable(shift_enable), .eop(eop), .eop_done(eop_done),
        .eop_error(eop_error), .bus_reset(bus_reset)
    );

    always #5 if (clk_en) clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Model: count consecutive SE0 strobes; the terminating non-SE0 strobe decides the outcome.
    task automatic model(input logic dp, input logic dm, input logic se, input logic r);
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (r) run = 0;
        else if (se) begin
            if (!dp && !dm) run = (run < 8) ? run + 1 : run;
            else begin
                if (run == 1) exp_err = 1'b1;
                else if (run == 2 || run == 3) begin
                    if (dp && !dm) exp_done = 1'b1;
                    else exp_err = 1'b1;
                end
                run = 0;
            end
        end
    endtask

    task automatic step(input int ls, input logic se, input logic r);
        @(negedge clk);
        d_plus       = (ls == LS_J) || (ls == LS_SE1);
        d_minus      = (ls == LS_K) || (ls == LS_SE1);
        shift_enable = se;
        rst          = r;
        @(posedge clk);
        model(d_plus, d_minus, se, r);
        #1;
        chk("eop", eop, !d_plus && !d_minus);
        chk("eop_done", eop_done, exp_done);
        chk("eop_error", eop_error, exp_err);
        chk("bus_reset", bus_reset, run >= 4);
    endtask

    task automatic comb(input logic dm, input logic dp, input logic exp);
        d_minus = dm;
        d_plus  = dp;
        #10;
        chk("eop_comb", eop, exp);
    endtask

    initial begin
        rst = 1'b1;
        comb(0, 0, 1); comb(1, 0, 0); comb(0, 1, 0);
        comb(1, 1, 0); comb(0, 0, 1); comb(1, 1, 0);
        clk_en = 1'b1;
        step(LS_J, 0, 1);
        step(LS_J, 1, 1);
        step(LS_J, 0, 0);
        // valid EOP
        step(LS_SE0, 1, 0); step(LS_SE0, 1, 0); step(LS_J, 1, 0); step(LS_J, 0, 0);
        // short SE0, then back-to-back valid EOP
        step(LS_SE0, 1, 0); step(LS_J, 1, 0);
        step(LS_SE0, 1, 0); step(LS_SE0, 1, 0); step(LS_SE0, 1, 0); step(LS_J, 1, 0);
        // K and SE1 terminators are malformed
        step(LS_SE0, 1, 0); step(LS_SE0, 1, 0); step(LS_K, 1, 0);
        step(LS_SE0, 1, 0); step(LS_SE0, 1, 0); step(LS_SE0, 1, 0); step(LS_SE1, 1, 0);
        // bus reset
        for (int i = 0; i < 5; i++) step(LS_SE0, 1, 0);
        step(LS_J, 1, 0); step(LS_J, 1, 0);
        // strobe gating
        step(LS_SE0, 1, 0);
        for (int i = 0; i < 10; i++) step((i % 2) ? LS_J : LS_K, 0, 0);
        step(LS_SE0, 1, 0);
        for (int i = 0; i < 10; i++) step(LS_SE1, 0, 0);
        step(LS_J, 1, 0); step(LS_J, 1, 0);
        // reset mid-operation
        step(LS_SE0, 1, 0); step(LS_SE0, 1, 0); step(LS_SE0, 1, 1); step(LS_J, 1, 0);
        step(LS_SE0, 1, 0); step(LS_J, 1, 0);
        // continuous strobe and random traffic biased toward SE0 runs
        for (int i = 0; i < 600; i++) begin
            int ls;
            ls = ($urandom_range(0, 1) == 0) ? LS_SE0 : int'($urandom_range(1, 3));
            step(ls, (i < 40) ? 1'b1 : ($urandom_range(0, 3) != 0), $urandom_range(0, 59) == 0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        fails++;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/eop_detect.md
EOP_DETECT -- requirements
Module: eop_detect

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: d_plus  input  1  USB D+ line level, already synchronized to clk.
REQ-004 SHALL have port: d_minus  input  1  USB D- line level, already synchronized to clk.
REQ-005 SHALL have port: shift_enable  input  1  one-cycle bit-sample strobe, one pulse per USB bit time.
REQ-006 SHALL have port: eop  output  1  combinational SE0 indicator.
REQ-007 SHALL have port: eop_done  output  1  registered one-cycle pulse on a valid complete EOP.
REQ-008 SHALL have port: eop_error  output  1  registered one-cycle pulse on a malformed EOP.
REQ-009 SHALL have port: bus_reset  output  1  registered level, high while SE0 lasts 4 or more bit samples.

Function
REQ-010 eop SHALL equal (d_plus==0 AND d_minus==0), purely combinational, independent of clk, rst and shift_enable; zero latency.
REQ-011 Line states SHALL be decoded as: SE0 = (0,0); J = d_plus 1, d_minus 0; K = d_plus 0, d_minus 1; SE1 = (1,1).
REQ-012 FSM states SHALL be IDLE, SE0_1, SE0_2, SE0_3, BUS_RST; transitions SHALL occur only on cycles where shift_enable=1; with shift_enable=0 the state holds.
REQ-013 IDLE: SE0 -> SE0_1; J/K/SE1 -> IDLE.
REQ-014 SE0_1: SE0 -> SE0_2; J/K/SE1 -> IDLE with eop_error pulse (single-bit SE0).
REQ-015 SE0_2: J -> IDLE with eop_done pulse; SE0 -> SE0_3; K or SE1 -> IDLE with eop_error pulse.
REQ-016 SE0_3: J -> IDLE with eop_done pulse; SE0 -> BUS_RST; K or SE1 -> IDLE with eop_error pulse.
REQ-017 BUS_RST: SE0 -> BUS_RST; any non-SE0 -> IDLE, no pulse.
REQ-018 eop_done and eop_error SHALL be high for exactly the one clk cycle following the triggering strobe edge, never simultaneously.
REQ-019 bus_reset SHALL be high in every cycle the registered state is BUS_RST, low otherwise.
REQ-020 Back-to-back: a SE0 sampled on the strobe after a done/error pulse SHALL enter SE0_1 normally.
REQ-021 shift_enable held high continuously SHALL be treated as a strobe every cycle.

Reset
REQ-022 rst=1 at a clk edge SHALL force state IDLE, eop_done=0, eop_error=0, bus_reset=0 on the following cycle, overriding shift_enable and any transition in progress.
REQ-023 eop SHALL remain combinational and valid during reset.

Verification
REQ-024 Combinational table, rst=1: (d_minus,d_plus) 00->eop=1, 10->0, 01->0, 11->0, 00->1, 11->0, each held 10 ns, checked without clock edges.
REQ-025 Valid EOP: strobes sample SE0, SE0, J -> eop_done=1 for one cycle after third strobe, eop_error=0, state IDLE.
REQ-026 Short SE0: strobes sample SE0, J -> eop_error one-cycle pulse, eop_done stays 0.
REQ-027 Bus reset: 5 SE0 strobes -> bus_reset rises after 4th strobe, stays high; J strobe -> bus_reset falls, no done/error pulse.
REQ-028 Strobe gating: SE0, SE0 with shift_enable=0 for 10 cycles between strobes, then J strobe -> single eop_done pulse only after the J strobe.
REQ-029 Reset mid-operation: SE0, SE0 strobes, rst=1 for one edge, then J strobe -> no eop_done, state IDLE.
